// File: rtl/valid_ready_watchdog_pkg.sv
// Shared types and constants for the valid/ready protocol watchdog.
package valid_ready_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STUCK = 2'd2
    } vrw_state_t;

    localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/vrw_sat_counter.sv
// Saturating up-counter with synchronous clear; a same-cycle increment wins over the clear.
module vrw_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d, base;

    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base != {Width{1'b1}})) begin
            cnt_d = base + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/valid_ready_watchdog.sv
// Passive valid/ready monitor: fire strobe, sticky stall/protocol flags, saturating transfer count.
// Define VALID_READY_WATCHDOG_MAXSTALL_EN to add the o_max_stall longest-stall output.
module valid_ready_watchdog
    import valid_ready_watchdog_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic               i_ready,
    input  logic [DW-1:0]      i_data,
    input  logic               i_clr,
    output logic               o_fire,
    output logic [1:0]         o_state,
    output logic [STALL_W-1:0] o_stall_cnt,
    output logic               o_timeout,
    output logic               o_drop_err,
    output logic               o_data_err,
`ifdef VALID_READY_WATCHDOG_MAXSTALL_EN
    output logic [STALL_W-1:0] o_max_stall,
`endif
    output logic [CNT_W-1:0]   o_xfer_cnt
);

    vrw_state_t         state_q;
    logic [DW-1:0]      held_q;
    logic               timeout_q, drop_q, data_q;
    logic [STALL_W-1:0] stall_cnt;

    logic fire, stall, busy, leave, hit, enter_stuck, timeout_ev, drop_ev, data_ev;

    assign fire  = i_valid & i_ready;
    assign stall = i_valid & ~i_ready;
    assign busy  = (state_q != IDLE);
    assign leave = busy & ~stall;
    // Stall count after this edge reaches TIMEOUT; in IDLE the count is 0, covering TIMEOUT==1.
    assign hit         = ((17'(stall_cnt) + 17'd1) == 17'(TIMEOUT));
    assign enter_stuck = stall & hit & (state_q != STUCK);
    assign timeout_ev  = enter_stuck | (stall & (state_q == STUCK));
    assign drop_ev     = busy & ~i_valid;
    assign data_ev     = busy & i_valid & (i_data != held_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            held_q    <= '0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (stall) begin
                        held_q  <= i_data;
                        state_q <= enter_stuck ? STUCK : WAIT;
                    end
                end
                WAIT, STUCK: begin
                    if (leave) begin
                        state_q <= IDLE;
                    end else if (enter_stuck) begin
                        state_q <= STUCK;
                    end
                end
                default: state_q <= IDLE;
            endcase
            timeout_q <= (timeout_q & ~i_clr) | timeout_ev;
            drop_q    <= (drop_q & ~i_clr) | drop_ev;
            data_q    <= (data_q & ~i_clr) | data_ev;
        end
    end

    vrw_sat_counter #(
        .Width (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~busy | leave),
        .inc_i (stall),
        .cnt_o (stall_cnt)
    );

    vrw_sat_counter #(
        .Width (CNT_W)
    ) u_xfer_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (i_clr),
        .inc_i (fire),
        .cnt_o (o_xfer_cnt)
    );

`ifdef VALID_READY_WATCHDOG_MAXSTALL_EN
    logic [STALL_W-1:0] max_stall_q, max_stall_d, max_base;

    always_comb begin
        max_base    = i_clr ? '0 : max_stall_q;
        max_stall_d = (leave && (stall_cnt > max_base)) ? stall_cnt : max_base;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_stall_q <= '0;
        end else begin
            max_stall_q <= max_stall_d;
        end
    end

    assign o_max_stall = max_stall_q;
`else
    // Longest-stall tracking is not built in this configuration.
`endif

    assign o_fire      = fire & rst;
    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt;
    assign o_timeout   = timeout_q;
    assign o_drop_err  = drop_q;
    assign o_data_err  = data_q;

endmodule

// File: tb/tb_valid_ready_watchdog.sv
// Self-checking bench for valid_ready_watchdog: per-cycle model compare plus literal checkpoints.
module tb_valid_ready_watchdog;

    localparam int unsigned DW      = 8;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int          XMAX    = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic          i_clr = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_fire;
    logic [1:0]    o_state;
    logic [15:0]   o_stall_cnt;
    logic          o_timeout, o_drop_err, o_data_err;
    logic [CNT_W-1:0] o_xfer_cnt;
`ifdef VALID_READY_WATCHDOG_MAXSTALL_EN
    logic [15:0]   o_max_stall;
`endif

    valid_ready_watchdog #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_data      (i_data),
        .i_clr       (i_clr),
        .o_fire      (o_fire),
        .o_state     (o_state),
        .o_stall_cnt (o_stall_cnt),
        .o_timeout   (o_timeout),
        .o_drop_err  (o_drop_err),
        .o_data_err  (o_data_err),
`ifdef VALID_READY_WATCHDOG_MAXSTALL_EN
        .o_max_stall (o_max_stall),
`endif
        .o_xfer_cnt  (o_xfer_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a stall is "open" from the first valid&!ready edge until a fire or drop closes it.
    bit          m_open = 0;
    int          m_len = 0;
    logic [7:0]  m_held = '0;
    bit          m_to = 0, m_dr = 0, m_de = 0;
    int          m_xfer = 0;
    int          m_max = 0;

    always @(negedge rst) begin
        m_open = 0; m_len = 0; m_held = '0;
        m_to = 0; m_dr = 0; m_de = 0; m_xfer = 0; m_max = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (i_clr) begin
                m_to = 0; m_dr = 0; m_de = 0; m_xfer = 0; m_max = 0;
            end
            if (i_valid && i_ready) m_xfer = (m_xfer < XMAX) ? m_xfer + 1 : XMAX;
            if (!m_open) begin
                if (i_valid && !i_ready) begin
                    m_open = 1; m_len = 1; m_held = i_data;
                    if (m_len >= int'(TIMEOUT)) m_to = 1;
                end
            end else begin
                if (i_valid && i_data != m_held) m_de = 1;
                if (i_valid && !i_ready) begin
                    if (m_len < 65535) m_len++;
                    if (m_len >= int'(TIMEOUT)) m_to = 1;
                end else begin
                    if (!i_valid) m_dr = 1;
                    if (m_len > m_max) m_max = m_len;
                    m_open = 0; m_len = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fire", 32'(o_fire), 32'(i_valid & i_ready & rst));
        chk("state", 32'(o_state), 32'(m_open ? (m_len >= int'(TIMEOUT) ? 2 : 1) : 0));
        chk("stall_cnt", 32'(o_stall_cnt), 32'(m_len));
        chk("timeout", 32'(o_timeout), 32'(m_to));
        chk("drop_err", 32'(o_drop_err), 32'(m_dr));
        chk("data_err", 32'(o_data_err), 32'(m_de));
        chk("xfer_cnt", 32'(o_xfer_cnt), 32'(m_xfer));
`ifdef VALID_READY_WATCHDOG_MAXSTALL_EN
        chk("max_stall", 32'(o_max_stall), 32'(m_max));
`endif
    end

    task automatic cycle(input logic v, input logic r, input logic [7:0] d, input logic c);
        i_valid = v; i_ready = r; i_data = d; i_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_xfer", 32'(o_xfer_cnt), 32'd0);
        chk("rst_flags", 32'({o_timeout, o_drop_err, o_data_err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Back-to-back fires stay in IDLE.
        for (int k = 0; k < 5; k++) cycle(1, 1, 8'(k), 0);
        chk("b2b_xfer", 32'(o_xfer_cnt), 32'd5);
        chk("b2b_state", 32'(o_state), 32'd0);
        chk("b2b_flags", 32'({o_timeout, o_drop_err, o_data_err}), 32'd0);
        cycle(0, 0, 0, 1);
        chk("clr_xfer", 32'(o_xfer_cnt), 32'd0);

        // Stall up to TIMEOUT, then fire.
        for (int k = 0; k < 3; k++) cycle(1, 0, 8'hA5, 0);
        chk("pre_to_state", 32'(o_state), 32'd1);
        chk("pre_to_flag", 32'(o_timeout), 32'd0);
        cycle(1, 0, 8'hA5, 0);
        chk("to_flag", 32'(o_timeout), 32'd1);
        chk("to_state", 32'(o_state), 32'd2);
        chk("to_cnt", 32'(o_stall_cnt), 32'd4);
        cycle(1, 1, 8'hA5, 0);
        chk("to_fire_state", 32'(o_state), 32'd0);
        chk("to_fire_xfer", 32'(o_xfer_cnt), 32'd1);
        chk("to_sticky", 32'(o_timeout), 32'd1);

        // Drop while stalled.
        cycle(0, 0, 0, 1);
        cycle(1, 0, 8'h11, 0);
        cycle(1, 0, 8'h11, 0);
        cycle(0, 0, 8'h11, 0);
        chk("drop_flag", 32'(o_drop_err), 32'd1);
        chk("drop_state", 32'(o_state), 32'd0);
        chk("drop_xfer", 32'(o_xfer_cnt), 32'd0);

        // Payload change while stalled.
        cycle(0, 0, 0, 1);
        cycle(1, 0, 8'h3C, 0);
        chk("data_pre", 32'(o_data_err), 32'd0);
        cycle(1, 0, 8'h3D, 0);
        chk("data_flag", 32'(o_data_err), 32'd1);
        cycle(1, 1, 8'h3D, 0);
        chk("data_xfer", 32'(o_xfer_cnt), 32'd1);

        // Transfer count saturation and clear racing a fire.
        cycle(0, 0, 0, 1);
        for (int k = 0; k < 9; k++) cycle(1, 1, 8'(k), 0);
        chk("sat_xfer", 32'(o_xfer_cnt), 32'd7);
        cycle(1, 1, 0, 1);
        chk("clr_fire_xfer", 32'(o_xfer_cnt), 32'd1);

        // Clear racing a drop: the drop flag wins.
        cycle(1, 0, 8'h55, 0);
        cycle(0, 0, 0, 1);
        chk("clr_drop_flag", 32'(o_drop_err), 32'd1);
        chk("clr_drop_xfer", 32'(o_xfer_cnt), 32'd0);

        // Asynchronous reset mid-stall.
        cycle(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(1, 0, 8'h77, 0);
        rst = 1'b0;
        i_ready = 1'b1;
        #1;
        chk("arst_fire", 32'(o_fire), 32'd0);
        chk("arst_state", 32'(o_state), 32'd0);
        chk("arst_cnt", 32'(o_stall_cnt), 32'd0);
        chk("arst_flags", 32'({o_timeout, o_drop_err, o_data_err}), 32'd0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        chk("post_rst_flags", 32'({o_timeout, o_drop_err, o_data_err}), 32'd0);

        // Longest stall across two stalls.
        for (int k = 0; k < 6; k++) cycle(1, 0, 8'h01, 0);
        cycle(1, 1, 8'h01, 0);
        for (int k = 0; k < 2; k++) cycle(1, 0, 8'h02, 0);
        cycle(1, 1, 8'h02, 0);
        chk("two_stall_xfer", 32'(o_xfer_cnt), 32'd2);
`ifdef VALID_READY_WATCHDOG_MAXSTALL_EN
        chk("max_stall_lit", 32'(o_max_stall), 32'd6);
`endif
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
